control_sequencer: RTL and testbench

//  Microcode sequencer for the 8-bit CPU. Steps a six-state T-cycle counter and decodes the IR opcode.

---
 rtl/control_sequencer_pkg.sv | 86 ++++++++
 rtl/control_sequencer_if.sv | 20 ++
 rtl/control_sequencer_t_state_counter.sv | 28 ++
 rtl/control_sequencer.sv | 63 ++++++
 tb/tb_control_sequencer.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the 8-bit CPU sequencer: opcodes, T-state encodings, control-word bit map
// and the microcode decode shared with the datapath.
package control_sequencer_pkg;

  localparam int unsigned OpcW    = 4;
  localparam int unsigned TStates = 6;

  localparam logic [OpcW-1:0] OpLda = 4'h0;
  localparam logic [OpcW-1:0] OpAdd = 4'h2;
  localparam logic [OpcW-1:0] OpSub = 4'h3;
  localparam logic [OpcW-1:0] OpOut = 4'hE;
  localparam logic [OpcW-1:0] OpHlt = 4'hF;

  typedef enum logic [2:0] {
    T1 = 3'd0,
    T2 = 3'd1,
    T3 = 3'd2,
    T4 = 3'd3,
    T5 = 3'd4,
    T6 = 3'd5
  } t_state_e;

  // Control-word bit indices; CwRomOutEn is the positive sense of low_rom_o_en.
  localparam int unsigned CwPcOutEn  = 0;
  localparam int unsigned CwPcInc    = 1;
  localparam int unsigned CwMarLoad  = 2;
  localparam int unsigned CwRomOutEn = 3;
  localparam int unsigned CwIrLoad   = 4;
  localparam int unsigned CwIrOutEn  = 5;
  localparam int unsigned CwALoad    = 6;
  localparam int unsigned CwAOutEn   = 7;
  localparam int unsigned CwBLoad    = 8;
  localparam int unsigned CwAluOutEn = 9;
  localparam int unsigned CwAluSub   = 10;
  localparam int unsigned CwOutLoad  = 11;
  localparam int unsigned CwW        = 12;

  typedef logic [CwW-1:0] ctrl_word_t;

  function automatic ctrl_word_t decode_ctrl(t_state_e t, logic [OpcW-1:0] op);
    ctrl_word_t cw;
    cw = '0;
    unique case (t)
      T1: begin cw[CwPcOutEn] = 1'b1; cw[CwMarLoad] = 1'b1; end
      T2: cw[CwPcInc] = 1'b1;
      T3: begin cw[CwRomOutEn] = 1'b1; cw[CwIrLoad] = 1'b1; end
      T4: begin
        if (op == OpLda || op == OpAdd || op == OpSub) begin
          cw[CwIrOutEn] = 1'b1;
          cw[CwMarLoad] = 1'b1;
        end else if (op == OpOut) begin
          cw[CwAOutEn]  = 1'b1;
          cw[CwOutLoad] = 1'b1;
        end
      end
      T5: begin
        if (op == OpLda) begin
          cw[CwRomOutEn] = 1'b1;
          cw[CwALoad]    = 1'b1;
        end else if (op == OpAdd || op == OpSub) begin
          cw[CwRomOutEn] = 1'b1;
          cw[CwBLoad]    = 1'b1;
        end
      end
      T6: begin
        if (op == OpAdd || op == OpSub) begin
          cw[CwAluOutEn] = 1'b1;
          cw[CwALoad]    = 1'b1;
          cw[CwAluSub]   = (op == OpSub);
        end
      end
      default: cw = '0;
    endcase
    return cw;
  endfunction

  // Last active step per opcode; the opcode is only valid from T4, so NOP retires after an empty T4.
  function automatic t_state_e last_step(logic [OpcW-1:0] op);
    t_state_e t;
    if (op == OpLda) t = T5;
    else if (op == OpAdd || op == OpSub) t = T6;
    else t = T4;
    return t;
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Sequencer <-> datapath control bundle: run/opcode in, T-state and control strobes out.
interface control_sequencer_if;
  logic                                      run;
  logic [control_sequencer_pkg::OpcW-1:0]    ir_opcode;
  logic [2:0]                                t_state;
  logic pc_out_en, pc_inc, mar_load, low_rom_o_en, ir_load, ir_out_en;
  logic a_load, a_out_en, b_load, alu_out_en, alu_sub, out_load, halted;

  modport master (
    input  run, ir_opcode,
    output t_state, pc_out_en, pc_inc, mar_load, low_rom_o_en, ir_load, ir_out_en,
           a_load, a_out_en, b_load, alu_out_en, alu_sub, out_load, halted
  );

  modport slave (
    output run, ir_opcode,
    input  t_state, pc_out_en, pc_inc, mar_load, low_rom_o_en, ir_load, ir_out_en,
           a_load, a_out_en, b_load, alu_out_en, alu_sub, out_load, halted
  );
endinterface

// File: rtl/control_sequencer_t_state_counter.sv
// T-state counter: advances on adv_i, wraps to T1 after last_i, holds otherwise.
module control_sequencer_t_state_counter
  import control_sequencer_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     adv_i,
  input  t_state_e last_i,
  output t_state_e t_state_o
);

  t_state_e t_state_d, t_state_q;

  always_comb begin
    t_state_d = t_state_q;
    if (adv_i) begin
      t_state_d = (t_state_q == last_i) ? T1 : t_state_e'(t_state_q + 3'd1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) t_state_q <= T1;
    else         t_state_q <= t_state_d;
  end

  assign t_state_o = t_state_q;

endmodule

// File: rtl/control_sequencer.sv
// Microcode sequencer top: halt flag plus Moore decode of (t_state, ir_opcode) into the control word.
// Optional CTRL_EARLY_END_EN: return to T1 right after each opcode's last active step.
module control_sequencer
  import control_sequencer_pkg::*;
(
  input  logic                clk,
  input  logic                low_rst,
  control_sequencer_if.master ctrl_io
);

  t_state_e   t_state, last;
  logic       halted_d, halted_q, halt_set, adv;
  ctrl_word_t cw;

  assign halt_set = ctrl_io.run && !halted_q && (t_state == T4) && (ctrl_io.ir_opcode == OpHlt);
  assign adv      = ctrl_io.run && !halted_q && !halt_set;

`ifdef CTRL_EARLY_END_EN
  // Fetch steps ignore the stale opcode; the wrap point only matters from T4 on.
  assign last = (t_state < T4) ? T6 : last_step(ctrl_io.ir_opcode);
`else
  assign last = T6;
`endif

  control_sequencer_t_state_counter u_t_state_counter (
    .clk_i     (clk),
    .rst_ni    (low_rst),
    .adv_i     (adv),
    .last_i    (last),
    .t_state_o (t_state)
  );

  always_comb begin
    halted_d = halted_q | halt_set;
  end

  always_ff @(posedge clk or negedge low_rst) begin
    if (!low_rst) halted_q <= 1'b0;
    else          halted_q <= halted_d;
  end

  // Reset gating is combinational so controls drop the instant low_rst falls.
  always_comb begin
    cw = decode_ctrl(t_state, ctrl_io.ir_opcode);
    if (!low_rst || halted_q) cw = '0;
  end

  assign ctrl_io.t_state      = t_state;
  assign ctrl_io.halted       = halted_q;
  assign ctrl_io.pc_out_en    = cw[CwPcOutEn];
  assign ctrl_io.pc_inc       = cw[CwPcInc];
  assign ctrl_io.mar_load     = cw[CwMarLoad];
  assign ctrl_io.low_rom_o_en = ~cw[CwRomOutEn];
  assign ctrl_io.ir_load      = cw[CwIrLoad];
  assign ctrl_io.ir_out_en    = cw[CwIrOutEn];
  assign ctrl_io.a_load       = cw[CwALoad];
  assign ctrl_io.a_out_en     = cw[CwAOutEn];
  assign ctrl_io.b_load       = cw[CwBLoad];
  assign ctrl_io.alu_out_en   = cw[CwAluOutEn];
  assign ctrl_io.alu_sub      = cw[CwAluSub];
  assign ctrl_io.out_load     = cw[CwOutLoad];

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer with a tiny datapath model for the full-program run.
module tb_control_sequencer;

  logic       clk = 1'b0;
  logic       low_rst;
  logic       run;
  logic       prog_mode;
  logic [3:0] op_drv;

  always #5 clk = ~clk;

  logic [7:0] mem [16];
  logic [3:0] pc_q, mar_q;
  logic [7:0] ir_q, a_q, b_q, out_q, dbus;
  int         out_cnt;
  int         excl_viol = 0;

  control_sequencer_if sif ();
  assign sif.run       = run;
  assign sif.ir_opcode = prog_mode ? ir_q[7:4] : op_drv;

  control_sequencer dut (
    .clk     (clk),
    .low_rst (low_rst),
    .ctrl_io (sif)
  );

  // Bit order: pc_out_en pc_inc mar_load low_rom_o_en ir_load ir_out_en
  //            a_load a_out_en b_load alu_out_en alu_sub out_load
  function automatic logic [11:0] ctrl_vec();
    return {sif.pc_out_en, sif.pc_inc, sif.mar_load, sif.low_rom_o_en, sif.ir_load,
            sif.ir_out_en, sif.a_load, sif.a_out_en, sif.b_load, sif.alu_out_en,
            sif.alu_sub, sif.out_load};
  endfunction

  always_comb begin
    dbus = 8'h00;
    if (sif.pc_out_en)          dbus = {4'h0, pc_q};
    else if (sif.ir_out_en)     dbus = {4'h0, ir_q[3:0]};
    else if (!sif.low_rom_o_en) dbus = mem[mar_q];
    else if (sif.a_out_en)      dbus = a_q;
    else if (sif.alu_out_en)    dbus = sif.alu_sub ? a_q - b_q : a_q + b_q;
  end

  always @(posedge clk or negedge low_rst) begin
    if (!low_rst) begin
      pc_q <= '0; mar_q <= '0; ir_q <= '0; a_q <= '0; b_q <= '0; out_q <= '0; out_cnt <= 0;
    end else begin
      if (sif.pc_inc)   pc_q  <= pc_q + 4'd1;
      if (sif.mar_load) mar_q <= dbus[3:0];
      if (sif.ir_load)  ir_q  <= dbus;
      if (sif.a_load)   a_q   <= dbus;
      if (sif.b_load)   b_q   <= dbus;
      if (sif.out_load) begin
        out_q   <= dbus;
        out_cnt <= out_cnt + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (int'(sif.pc_out_en) + int'(sif.ir_out_en) + int'(sif.a_out_en) + int'(sif.alu_out_en)
        + int'(!sif.low_rom_o_en) > 1) excl_viol++;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(string tag, logic [15:0] act, logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_step(string tag, int t, logic [11:0] c);
    #1;
    check_eq({tag, "_t"}, 16'(sif.t_state), 16'(t));
    check_eq({tag, "_cw"}, 16'(ctrl_vec()), 16'(c));
  endtask

  function automatic int steps(logic [3:0] op);
`ifdef CTRL_EARLY_END_EN
    if (op == 4'h0) return 5;
    if (op == 4'h2 || op == 4'h3) return 6;
    return 4;
`else
    return 6 + 0 * int'(op);
`endif
  endfunction

  task automatic exec(logic [3:0] op, logic [11:0] c4, logic [11:0] c5, logic [11:0] c6);
    logic [11:0] exp [6];
    exp    = '{12'hB00, 12'h500, 12'h080, c4, c5, c6};
    op_drv = op;
    for (int i = 0; i < steps(op); i++) begin
      check_step($sformatf("op%0h_T%0d", op, i + 1), i, exp[i]);
      tick();
    end
    check_step($sformatf("op%0h_wrap", op), 0, 12'hB00);
  endtask

  initial begin
    low_rst = 1'b0; run = 1'b0; prog_mode = 1'b0; op_drv = 4'h0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    mem[0] = 8'h08; mem[1] = 8'h39; mem[2] = 8'hE0; mem[3] = 8'hF0;
    mem[8] = 8'h20; mem[9] = 8'h05;

    repeat (3) @(negedge clk);
    check_step("reset", 0, 12'h100);
    check_eq("reset_halted", 16'(sif.halted), 16'h0);

    low_rst = 1'b1; run = 1'b1;
    exec(4'h0, 12'h340, 12'h020, 12'h100);  // LDA
    exec(4'h3, 12'h340, 12'h008, 12'h126);  // SUB
    exec(4'h2, 12'h340, 12'h008, 12'h124);  // ADD
    exec(4'h5, 12'h100, 12'h100, 12'h100);  // NOP

    op_drv = 4'h0;
    tick();
    run = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_step($sformatf("hold%0d", i), 1, 12'h500);
    end
    run = 1'b1;
    tick();
    check_step("resume_T3", 2, 12'h080);
    tick();
    tick();
    check_step("mid_T5", 4, 12'h020);
    #1 low_rst = 1'b0;
    #1;
    check_eq("arst_t", 16'(sif.t_state), 16'h0);
    check_eq("arst_cw", 16'(ctrl_vec()), 16'h100);
    @(negedge clk);
    low_rst = 1'b1;
    check_step("arst_rel", 0, 12'hB00);

    exec(4'hE, 12'h111, 12'h100, 12'h100);  // OUT

    op_drv = 4'hF;
    check_step("hlt_T1", 0, 12'hB00);
    tick();
    check_step("hlt_T2", 1, 12'h500);
    tick();
    check_step("hlt_T3", 2, 12'h080);
    tick();
    check_step("hlt_T4", 3, 12'h100);
    check_eq("hlt_T4_halted", 16'(sif.halted), 16'h0);
    tick();
    check_eq("hlt_set", 16'(sif.halted), 16'h1);
    for (int i = 0; i < 20; i++) begin
      tick();
      check_step($sformatf("frozen%0d", i), 3, 12'h000 | 12'h100);
    end
    #1 low_rst = 1'b0;
    #1;
    check_eq("hrst_halted", 16'(sif.halted), 16'h0);
    check_eq("hrst_t", 16'(sif.t_state), 16'h0);
    check_eq("hrst_cw", 16'(ctrl_vec()), 16'h100);

    // Program: LDA 8; SUB 9; OUT; HLT with mem[8]=0x20, mem[9]=0x05 -> OUT = 0x1B.
    prog_mode = 1'b1;
    @(negedge clk);
    low_rst = 1'b1;
    for (int i = 0; i < 100 && !sif.halted; i++) tick();
    check_eq("prog_halted", 16'(sif.halted), 16'h1);
    check_eq("prog_out_cnt", 16'(out_cnt), 16'd1);
    check_eq("prog_out_val", 16'(out_q), 16'h1B);
    check_eq("prog_pc", 16'(pc_q), 16'h4);
    check_eq("bus_excl", 16'(excl_viol), 16'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
